floor_arbiter: RTL and testbench

Shares one combinational single-precision floor datapath among NREQ independent requesters. Uses round-robin arbitration and a one-entry registered result stage. Each requester uses a valid/ready handshake, and each result is returned tagged with the requester's index. It sits between the integer/FPU issue ports and the floor unit, so the floor logic is not replicated per port.

---
 rtl/floor_arbiter.sv | 68 ++++++
 tb/tb_floor_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/floor_arbiter.sv
// floor_arbiter: round-robin sharing of one single-precision floor datapath with a one-entry result register
module floor_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [31:0]          resp_data,
   output logic [ID_W-1:0]      resp_id,
   output logic [15:0]          done_cnt
);
   logic [ID_W-1:0] rr, g;
   logic found, can_acc, acc;

   function automatic logic [31:0] fl(input logic [31:0] a);
      logic [7:0] e;
      logic [22:0] fm, tm;
      logic [23:0] sum;
      e   = a[30:23];
      fm  = 23'h7FFFFF >> (e - 8'd127);
      tm  = a[22:0] & ~fm;
      sum = {1'b0, tm} + ({1'b0, fm} + 24'd1);
      if (a == 32'h80000000) fl = a;
      else if (e < 8'd127) fl = a[31] ? 32'hBF800000 : 32'h0;
      else if (e > 8'd150) fl = a;
      else if (a[31] && |(a[22:0] & fm)) fl = sum[23] ? {a[31], e + 8'd1, 23'd0} : {a[31], e, sum[22:0]};
      else fl = {a[31], e, tm};
   endfunction

   always_comb begin
      g = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++)
         if (!found && req_valid[(int'(rr) + k) % NREQ]) begin
            found = 1'b1;
            g = ID_W'((int'(rr) + k) % NREQ);
         end
   end

   assign can_acc   = ~resp_valid | resp_ready;
   assign req_ready = (rstn && can_acc && found) ? NREQ'(1) << g : '0;
   assign acc       = |(req_valid & req_ready);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= '0;
         done_cnt   <= '0;
         rr         <= '0;
      end else begin
         if (resp_valid && resp_ready) done_cnt <= done_cnt + 16'd1;
         if (acc) begin
            resp_data  <= fl(req_data[32*g +: 32]);
            resp_id    <= g;
            resp_valid <= 1'b1;
            rr         <= (int'(g) == NREQ - 1) ? '0 : g + ID_W'(1);
         end else if (resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_floor_arbiter.sv
// tb_floor_arbiter: directed and randomized checks of floor_arbiter against a behavioural model
module tb_floor_arbiter;
   localparam int NREQ = 4;
   localparam int ID_W = 2;

   logic clk = 1'b0;
   logic rstn;
   logic [NREQ-1:0] req_valid;
   logic [32*NREQ-1:0] req_data;
   logic [NREQ-1:0] req_ready;
   logic resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic [ID_W-1:0] resp_id;
   logic [15:0] done_cnt;

   int total = 0, bad = 0;
   int m_rr, m_id, m_cnt;
   bit m_vld;
   logic [31:0] m_data;
   logic [NREQ-1:0] acc_mask;
   logic [31:0] specials [6] = '{32'h80000000, 32'h0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hC07FFFFF};

   floor_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
      .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Floor by integer magnitude, then re-encode the integer as a float
   function automatic logic [31:0] ref_floor(input logic [31:0] a);
      int e, sh, p;
      longint sig, mag;
      e = int'(a[30:23]);
      if (a == 32'h80000000) return a;
      if (e < 127) return a[31] ? 32'hBF800000 : 32'h0;
      if (e > 150) return a;
      sig = longint'({1'b1, a[22:0]});
      sh  = 150 - e;
      mag = sig >> sh;
      if (a[31] && (sig % (64'd1 << sh)) != 0) mag++;
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      return {a[31], 8'(127 + p), 23'((mag << (23 - p)) & 64'h7FFFFF)};
   endfunction

   function automatic logic [31:0] rnd_val();
      if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 5)];
      return {1'($urandom), 8'($urandom_range(118, 160)), 23'($urandom)};
   endfunction

   task automatic model_reset();
      m_rr = 0; m_vld = 0; m_data = 0; m_id = 0; m_cnt = 0;
   endtask

   task automatic tick();
      logic [NREQ-1:0] er;
      int g;
      er = '0;
      g = -1;
      #1;
      for (int k = 0; k < NREQ; k++)
         if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      if (rstn && (!m_vld || resp_ready) && g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("resp_valid", 32'(resp_valid), 32'(m_vld));
      chk("resp_data", resp_data, m_data);
      chk("resp_id", 32'(resp_id), 32'(m_id));
      chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
      acc_mask = er;
      @(posedge clk);
      #1;
      if (!rstn) model_reset();
      else begin
         if (m_vld && resp_ready) m_cnt = (m_cnt + 1) % 65536;
         if (er != 0) begin
            m_data = ref_floor(req_data[32*g +: 32]);
            m_id = g;
            m_vld = 1;
            m_rr = (g + 1) % NREQ;
         end else if (resp_ready) m_vld = 0;
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req_valid = '0;
      tick();
      rstn = 1'b1;
   endtask

   logic [31:0] neg_in [3] = '{32'hBFC00000, 32'hBE800000, 32'h80000000};
   logic [31:0] neg_out [3] = '{32'hC0000000, 32'hBF800000, 32'h80000000};
   logic [31:0] big_in [3] = '{32'hC07FFFFF, 32'h4B800001, 32'h7FC00000};
   logic [31:0] big_out [3] = '{32'hC0800000, 32'h4B800001, 32'h7FC00000};

   initial begin
      logic [31:0] held_d;
      logic [ID_W-1:0] held_id;
      rstn = 1'b0;
      req_valid = '0;
      req_data = '0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      do_reset();
      chk("reset_valid", 32'(resp_valid), 0);
      chk("reset_cnt", 32'(done_cnt), 0);

      req_valid = 4'b0010;
      req_data[32 +: 32] = 32'h3FC00000;
      #1 chk("single_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      chk("single_data", resp_data, 32'h3F800000);
      chk("single_id", 32'(resp_id), 1);

      req_valid = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         req_data[31:0] = neg_in[i];
         tick();
         chk("neg_valid", 32'(resp_valid), 1);
         chk("neg_data", resp_data, neg_out[i]);
      end
      for (int i = 0; i < 3; i++) begin
         req_data[31:0] = big_in[i];
         tick();
         chk("big_data", resp_data, big_out[i]);
      end
      req_valid = '0;
      tick();

      do_reset();
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'h40000000 + 32'(i << 20);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_id", 32'(resp_id), 32'(i % NREQ));
      end
      req_valid = '0;
      tick();
      chk("rr_cnt", 32'(done_cnt), 5);

      req_valid = '1;
      tick();
      resp_ready = 1'b0;
      held_d = resp_data;
      held_id = resp_id;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ready", 32'(req_ready), 0);
         chk("stall_data", resp_data, held_d);
         chk("stall_id", 32'(resp_id), 32'(held_id));
      end
      resp_ready = 1'b1;
      #1 chk("unstall_accept", 32'(req_ready != 0), 1);
      tick();
      chk("unstall_id", 32'(resp_id), 32'((held_id + 1) % NREQ));

      resp_ready = 1'b0;
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("rst_stall_valid", 32'(resp_valid), 0);
      chk("rst_stall_cnt", 32'(done_cnt), 0);
      resp_ready = 1'b1;
      req_valid = 4'b1100;
      #1 chk("rst_first_grant", 32'(req_ready), 32'h4);
      tick();

      req_valid = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++)
            if ((acc_mask[i] || !req_valid[i]) && $urandom_range(0, 2) != 0) begin
               req_valid[i] = 1'b1;
               req_data[32*i +: 32] = rnd_val();
            end else if (acc_mask[i]) req_valid[i] = 1'b0;
         resp_ready = $urandom_range(0, 3) != 0;
         rstn = $urandom_range(0, 199) != 0;
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
